// File: rtl/ssd_scan_rx_pkg.sv
// Shared seven-segment definitions: active-low segment codes, blank code,
// default timing parameters and the receiver FSM state type.
package ssd_scan_rx_pkg;

  localparam int STABLE_CYC_DEF  = 16;
  localparam int TIMEOUT_CYC_DEF = 524288;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry i is the {a..g} active-low code that displays hex digit i.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/ssd_scan_rx_decode.sv
// Inverse seven-segment lookup: maps a captured segment pattern back to its
// hex digit and flags hex and blank patterns.
module ssd_pattern_decode
  import ssd_scan_rx_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    digit  = '0;
    is_hex = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODES[i]) begin
        digit  = 4'(i);
        is_hex = 1'b1;
      end
    end
  end

  assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/ssd_scan_rx.sv
// Receiver for a multiplexed 4-digit seven-segment display: synchronizes the
// pins, captures stable anode/segment patterns and assembles complete frames.
module ssd_scan_rx
  import ssd_scan_rx_pkg::*;
#(
  parameter int STABLE_CYC  = STABLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  logic [10:0]      pat_s1, pat_s2, pat_q;
  logic             changed;
  logic [CW-1:0]    cnt;
  state_t           state, state_next;
  logic [3:0]       sel;
  logic             capture, cap_one, cap_multi;
  logic [3:0]       dec_digit;
  logic             dec_hex, dec_blank;
  logic [3:0]       seen;
  logic [3:0][3:0]  sh_digit;
  logic [3:0]       sh_valid;
  logic [TW-1:0]    tmo_cnt;
  logic             frame_fire, tmo_hit;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pat_s1 <= '0;
      pat_s2 <= '0;
      pat_q  <= '0;
      cnt    <= '0;
      state  <= ST_WAIT;
    end else begin
      pat_s1 <= {seg, an};
      pat_s2 <= pat_s1;
      pat_q  <= pat_s2;
      if (changed)          cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + CW'(1);
      state  <= state_next;
    end
  end

  assign changed = (pat_s2 != pat_q);

  always_comb begin
    state_next = state;
    unique case (state)
      ST_WAIT:    if (cnt == CW'(STABLE_CYC - 1)) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    state_next = ST_HOLD;
      default:    state_next = ST_WAIT;
    endcase
    if (changed) state_next = ST_WAIT;
  end

  // pat_q still holds the stable pattern during the capture cycle, even if
  // the pins move on in that same cycle.
  assign capture   = (state == ST_CAPTURE);
  assign sel       = ~pat_q[3:0];
  assign cap_one   = capture && $onehot(sel);
  assign cap_multi = capture && !$onehot0(sel);

  ssd_pattern_decode u_decode (
    .pattern  (pat_q[10:4]),
    .digit    (dec_digit),
    .is_hex   (dec_hex),
    .is_blank (dec_blank)
  );

  assign frame_fire = (seen == 4'b1111);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYC - 1)) && !cap_one;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      // NOTE: the shadow digits are a handful of flops, cleared on reset so a discarded frame leaves nothing behind.
      sh_digit    <= '0;
      sh_valid    <= '0;
      seen        <= '0;
      tmo_cnt     <= '0;
      digits      <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_done  <= frame_fire;
      err_pattern <= cap_one && !dec_hex && !dec_blank;
      err_anode   <= cap_multi;

      if (cap_one)                          tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYC)) tmo_cnt <= tmo_cnt + TW'(1);

      // A completing frame takes priority over a coincident timeout.
      if (frame_fire) begin
        digits      <= sh_digit;
        digit_valid <= sh_valid;
        seen        <= '0;
        stale       <= 1'b0;
      end else if (tmo_hit) begin
        digit_valid <= '0;
        seen        <= '0;
        stale       <= 1'b1;
      end

      if (cap_one) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) begin
            seen[i]     <= 1'b1;
            sh_digit[i] <= dec_digit;
            sh_valid[i] <= dec_hex;
          end
        end
      end
    end
  end

endmodule
